module_disp_7_seg_scanner: RTL and testbench

Parametrised, time-multiplexed hex-to-7-segment display controller. It is the next generation of the fixed 4-digit control block, generalised to N digits with:
- per-digit decimal points and digit enables
- optional leading-zero blanking
- frame-synchronised double-buffered data load, so displayed values never tear mid-frame.

It sits between a data source (LFSR, PIPO register, counters) and the board's anode/cathode pins.

---
 rtl/module_disp_7_seg_scanner.sv | 164 ++++++++++++++++
 tb/tb_module_disp_7_seg_scanner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/module_disp_7_seg_scanner.sv
// Time-multiplexed N-digit hex-to-7-segment scanner with frame-synchronised
// double-buffered load, per-digit decimal points/enables and leading-zero blanking.
module module_disp_7_seg_scanner #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned CLK_DIV    = 10000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic                    i_blank_lz,
  input  logic                    i_load,
  output logic                    o_pending,
  output logic                    o_frame_tick,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] pat;
    unique case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

  logic [DivW-1:0]         div_q, div_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                    pending_q, pending_d;
  logic                    tick_q, tick_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;

  logic                    slot_end;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_vis;

  assign slot_end  = (div_q == DivLast);
  assign frame_end = slot_end && (idx_q == IdxLast);

  // Scan counters.
  always_comb begin
    div_d = slot_end ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
    tick_d = frame_end;
  end

  // Double buffer: loads land in the pending regs and move to the display regs
  // only at a frame boundary; a load on the boundary itself bypasses straight in.
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;
    if (i_load && !frame_end) begin
      pend_data_d = i_data;
      pend_dp_d   = i_dp;
      pending_d   = 1'b1;
    end
    if (frame_end) begin
      if (i_load) begin
        disp_data_d = i_data;
        disp_dp_d   = i_dp;
      end else if (pending_q) begin
        disp_data_d = pend_data_q;
        disp_dp_d   = pend_dp_q;
      end
      pending_d = 1'b0;
    end
  end

  // A digit is blanked when it and every digit above it is a zero with no dp.
  always_comb begin
    zero_run = i_blank_lz;
    blank    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp_data_q[4*k +: 4] == 4'h0) && !disp_dp_q[k];
      blank[k] = (k != 0) && zero_run;
    end
  end

  // Output stage, registered from the current scan index.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_vis = 1'b0;
    an_d    = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_nib = disp_data_q[4*k +: 4];
        cur_dp  = disp_dp_q[k];
        cur_vis = i_digit_en[k] && !blank[k];
        an_d[k] = !(i_digit_en[k] && !blank[k]);
      end
    end
    seg_d = cur_vis ? {~cur_dp, decode_hex(cur_nib)} : 8'hFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      pending_q   <= 1'b0;
      tick_q      <= 1'b0;
      an_q        <= '1;
      seg_q       <= 8'hFF;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      pending_q   <= pending_d;
      tick_q      <= tick_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign o_pending    = pending_q;
  assign o_frame_tick = tick_q;
  assign an           = an_q;
  assign seg          = seg_q;

endmodule

// File: tb/tb_module_disp_7_seg_scanner.sv
// Directed self-checking bench for module_disp_7_seg_scanner, 4 digits, 4 clocks per slot.
module tb_module_disp_7_seg_scanner;

  localparam int unsigned ND = 4;
  localparam int unsigned CD = 4;

  logic          clk;
  logic          rst;
  logic [15:0]   i_data;
  logic [3:0]    i_dp;
  logic [3:0]    i_digit_en;
  logic          i_blank_lz;
  logic          i_load;
  logic          o_pending;
  logic          o_frame_tick;
  logic [3:0]    an;
  logic [7:0]    seg;

  int n_cmp;
  int n_err;
  int ecount;

  module_disp_7_seg_scanner #(
    .NUM_DIGITS (ND),
    .CLK_DIV    (CD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_data       (i_data),
    .i_dp         (i_dp),
    .i_digit_en   (i_digit_en),
    .i_blank_lz   (i_blank_lz),
    .i_load       (i_load),
    .o_pending    (o_pending),
    .o_frame_tick (o_frame_tick),
    .an           (an),
    .seg          (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge number e since reset release.
  task automatic goto(input int e);
    while (ecount < e) begin
      @(posedge clk);
      ecount++;
    end
    #1;
  endtask

  task automatic chk_slot(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
    chk({tag, "_an"}, {12'b0, an}, {12'b0, exp_an});
    chk({tag, "_seg"}, {8'b0, seg}, {8'b0, exp_seg});
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    ecount     = 0;
    rst        = 1'b0;
    i_data     = 16'h0;
    i_dp       = 4'h0;
    i_digit_en = 4'hF;
    i_blank_lz = 1'b0;
    i_load     = 1'b0;

    // 1: reset state, then zeros on every digit and a 16-clock frame tick
    repeat (3) @(posedge clk);
    #1;
    chk_slot("rst", 4'b1111, 8'hFF);
    chk("rst_pend", {15'b0, o_pending}, 16'd0);
    chk("rst_tick", {15'b0, o_frame_tick}, 16'd0);
    @(negedge clk);
    rst    = 1'b1;
    ecount = 0;
    goto(1);
    chk_slot("t1_d0", 4'b1110, 8'hC0);
    goto(6);
    chk_slot("t1_d1", 4'b1101, 8'hC0);
    goto(10);
    chk_slot("t1_d2", 4'b1011, 8'hC0);
    goto(14);
    chk_slot("t1_d3", 4'b0111, 8'hC0);
    goto(15);
    chk("t1_tick15", {15'b0, o_frame_tick}, 16'd0);
    goto(16);
    chk("t1_tick16", {15'b0, o_frame_tick}, 16'd1);
    goto(17);
    chk("t1_tick17", {15'b0, o_frame_tick}, 16'd0);
    goto(32);
    chk("t1_tick32", {15'b0, o_frame_tick}, 16'd1);

    // 2: mid-frame load of 12AF, committed at the next boundary
    goto(33);
    i_data = 16'h12AF;
    i_load = 1'b1;
    goto(34);
    i_load = 1'b0;
    chk("t2_pend34", {15'b0, o_pending}, 16'd1);
    goto(47);
    chk("t2_pend47", {15'b0, o_pending}, 16'd1);
    goto(48);
    chk("t2_pend48", {15'b0, o_pending}, 16'd0);
    chk("t2_tick48", {15'b0, o_frame_tick}, 16'd1);
    goto(50);
    chk_slot("t2_d0", 4'b1110, 8'h8E);
    goto(54);
    chk_slot("t2_d1", 4'b1101, 8'h88);
    goto(58);
    chk_slot("t2_d2", 4'b1011, 8'hA4);
    goto(62);
    chk_slot("t2_d3", 4'b0111, 8'hF9);

    // 3: two loads in one frame, last one wins
    goto(66);
    i_data = 16'h1111;
    i_load = 1'b1;
    goto(67);
    i_data = 16'h2222;
    goto(68);
    i_load = 1'b0;
    chk("t3_pend", {15'b0, o_pending}, 16'd1);
    goto(70);
    chk_slot("t3_old_d1", 4'b1101, 8'h88);
    goto(82);
    chk_slot("t3_d0", 4'b1110, 8'hA4);
    goto(86);
    chk_slot("t3_d1", 4'b1101, 8'hA4);
    goto(90);
    chk_slot("t3_d2", 4'b1011, 8'hA4);
    goto(94);
    chk_slot("t3_d3", 4'b0111, 8'hA4);

    // 4: load on the boundary cycle itself, then leading-zero blanking
    goto(95);
    i_data     = 16'h0005;
    i_load     = 1'b1;
    i_blank_lz = 1'b1;
    goto(96);
    i_load = 1'b0;
    chk("t4_pend96", {15'b0, o_pending}, 16'd0);
    goto(98);
    chk_slot("t4_d0", 4'b1110, 8'h92);
    goto(99);
    i_dp   = 4'b0100;
    i_load = 1'b1;
    goto(100);
    i_load = 1'b0;
    goto(102);
    chk_slot("t4_d1_blank", 4'b1111, 8'hFF);
    goto(106);
    chk_slot("t4_d2_blank", 4'b1111, 8'hFF);
    goto(110);
    chk_slot("t4_d3_blank", 4'b1111, 8'hFF);
    goto(114);
    chk_slot("t4_dp_d0", 4'b1110, 8'h92);
    goto(115);
    i_data     = 16'h8888;
    i_dp       = 4'b0000;
    i_load     = 1'b1;
    goto(116);
    i_load = 1'b0;
    goto(118);
    chk_slot("t4_dp_d1", 4'b1101, 8'hC0);
    goto(122);
    chk_slot("t4_dp_d2", 4'b1011, 8'h40);
    goto(126);
    chk_slot("t4_dp_d3", 4'b1111, 8'hFF);

    // 5: digit enables 0101 with 8888
    goto(127);
    i_blank_lz = 1'b0;
    i_digit_en = 4'b0101;
    goto(130);
    chk_slot("t5_d0", 4'b1110, 8'h80);
    goto(134);
    chk_slot("t5_d1", 4'b1111, 8'hFF);
    goto(138);
    chk_slot("t5_d2", 4'b1011, 8'h80);
    goto(142);
    chk_slot("t5_d3", 4'b1111, 8'hFF);

    // 6: asynchronous reset mid-slot with a load pending
    goto(145);
    i_digit_en = 4'hF;
    i_data     = 16'h3333;
    i_load     = 1'b1;
    goto(146);
    i_load = 1'b0;
    goto(147);
    chk("t6_pend_pre", {15'b0, o_pending}, 16'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_slot("t6_async", 4'b1111, 8'hFF);
    chk("t6_async_pend", {15'b0, o_pending}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b1;
    ecount = 0;
    goto(2);
    chk_slot("t6_d0", 4'b1110, 8'hC0);
    chk("t6_pend", {15'b0, o_pending}, 16'd0);
    goto(14);
    chk_slot("t6_d3", 4'b0111, 8'hC0);
    goto(15);
    chk("t6_tick15", {15'b0, o_frame_tick}, 16'd0);
    goto(16);
    chk("t6_tick16", {15'b0, o_frame_tick}, 16'd1);
    chk("t6_pend16", {15'b0, o_pending}, 16'd0);
    goto(18);
    chk_slot("t6_after_d0", 4'b1110, 8'hC0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
